// File: rtl/collectible_ctrl.sv
// Game-logic controller for the collectible square: spawns it at an LFSR-chosen
// position, expires it after a frame timeout and detects player collection.
module collectible_ctrl #(
  parameter int          H_ACTIVE       = 800,
  parameter int          V_ACTIVE       = 600,
  parameter int          SQ_SIZE        = 10,
  parameter int          PLAYER_W       = 32,
  parameter int          PLAYER_H       = 32,
  parameter int          TIMEOUT_FRAMES = 300,
  parameter int          GAP_FRAMES     = 30,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          MAX_TRIES      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        score_clr,
  input  logic        vblnk,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  output logic [10:0] sq_x,
  output logic [10:0] sq_y,
  output logic        sq_visible,
  output logic        collect_pulse,
  output logic [15:0] score
);

  localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - SQ_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - SQ_SIZE);
  localparam logic [10:0] X_SPAN   = 11'(H_ACTIVE - SQ_SIZE + 1);
  localparam logic [10:0] Y_SPAN   = 11'(V_ACTIVE - SQ_SIZE + 1);
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          TRY_W    = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_FRAMES - 1);
  localparam logic [15:0] GAP_LAST = 16'(((GAP_FRAMES == 0) ? 1 : GAP_FRAMES) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    ACTIVE,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             vblnk_q;
  logic [15:0]      cnt_q, cnt_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             x_ok_q, x_ok_d;
  logic             y_ok_q, y_ok_d;
  logic [10:0]      sq_x_q, sq_x_d;
  logic [10:0]      sq_y_q, sq_y_d;
  logic             vis_q, vis_d;
  logic             pulse_q, pulse_d;
  logic [15:0]      score_q, score_d;

  logic        tick;
  logic [10:0] cx, cy;
  logic        cx_ok, cy_ok;
  logic [10:0] cx_fold, cy_fold;
  logic [11:0] px_w, py_w, sx_w, sy_w;
  logic        hit;
  logic [15:0] score_inc;

  assign tick   = vblnk & ~vblnk_q;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cx      = {1'b0, lfsr_q[9:0]};
  assign cy      = {1'b0, lfsr_q[15:6]};
  assign cx_ok   = (cx <= X_MAX);
  assign cy_ok   = (cy <= Y_MAX);
  // Fallback after the attempt limit: fold an out-of-range candidate back into range.
  assign cx_fold = cx_ok ? cx : (cx - X_SPAN);
  assign cy_fold = cy_ok ? cy : (cy - Y_SPAN);

  assign px_w = {1'b0, player_x};
  assign py_w = {1'b0, player_y};
  assign sx_w = {1'b0, sq_x_q};
  assign sy_w = {1'b0, sq_y_q};
  assign hit  = (px_w < sx_w + 12'(SQ_SIZE)) && (sx_w < px_w + 12'(PLAYER_W)) &&
                (py_w < sy_w + 12'(SQ_SIZE)) && (sy_w < py_w + 12'(PLAYER_H));

  assign score_inc = (score_q == 16'hFFFF) ? score_q : (score_q + 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    x_ok_d  = x_ok_q;
    y_ok_d  = y_ok_q;
    sq_x_d  = sq_x_q;
    sq_y_d  = sq_y_q;
    vis_d   = vis_q;
    pulse_d = 1'b0;
    score_d = score_q;

    unique case (state_q)
      IDLE: begin
        vis_d = 1'b0;
        if (enable && tick) begin
          state_d = SPAWN;
          tries_d = '0;
          x_ok_d  = 1'b0;
          y_ok_d  = 1'b0;
        end
      end

      SPAWN: begin
        if (tries_q >= TRY_LIMIT) begin
          if (!x_ok_q) sq_x_d = cx_fold;
          if (!y_ok_q) sq_y_d = cy_fold;
          x_ok_d  = 1'b1;
          y_ok_d  = 1'b1;
          state_d = ACTIVE;
          vis_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          if (!x_ok_q && cx_ok) begin
            sq_x_d = cx;
            x_ok_d = 1'b1;
          end
          if (!y_ok_q && cy_ok) begin
            sq_y_d = cy;
            y_ok_d = 1'b1;
          end
          if (x_ok_d && y_ok_d) begin
            state_d = ACTIVE;
            vis_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end

      ACTIVE: begin
        // Collision is tested before the timeout so a same-frame tie still scores.
        if (tick) begin
          if (hit) begin
            pulse_d = 1'b1;
            score_d = score_inc;
            vis_d   = 1'b0;
            cnt_d   = '0;
            state_d = GAP;
          end else if (cnt_q == TO_LAST) begin
            vis_d   = 1'b0;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            state_d = SPAWN;
            cnt_d   = '0;
            tries_d = '0;
            x_ok_d  = 1'b0;
            y_ok_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      vis_d   = 1'b0;
      cnt_d   = '0;
      pulse_d = 1'b0;
      score_d = score_q;
      sq_x_d  = sq_x_q;
      sq_y_d  = sq_y_q;
    end

    if (score_clr) score_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      vblnk_q <= 1'b0;
      cnt_q   <= '0;
      tries_q <= '0;
      x_ok_q  <= 1'b0;
      y_ok_q  <= 1'b0;
      sq_x_q  <= '0;
      sq_y_q  <= '0;
      vis_q   <= 1'b0;
      pulse_q <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vblnk_q <= vblnk;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      x_ok_q  <= x_ok_d;
      y_ok_q  <= y_ok_d;
      sq_x_q  <= sq_x_d;
      sq_y_q  <= sq_y_d;
      vis_q   <= vis_d;
      pulse_q <= pulse_d;
      score_q <= score_d;
    end
  end

  assign sq_x          = sq_x_q;
  assign sq_y          = sq_y_q;
  assign sq_visible    = vis_q;
  assign collect_pulse = pulse_q;
  assign score         = score_q;

endmodule
